rom_read_arbiter: RTL

- Shares one combinational, single-port 8-bit ROM (address/data/read_en/ce interface) between two independent read requesters.
- Arbitrates with a 2-way round-robin scheme.
- Drives the ROM chip-enable and read-enable only during a single access cycle, to save power.
- Registers the returned data and presents it with a per-requester valid pulse. Sits between the ROM instance and its client blocks.

---
 rtl/rom_arb_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 30 +++
 rtl/rom_read_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/rom_arb_pkg.sv
//------------------------------------------------------------------------------
// rom_arb_pkg : shared state encoding and requester ids for rom_read_arbiter
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// rr_arb2  : combinational 2-way round-robin pick
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2
  import rom_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  output logic any_req,
  output logic winner
);

  always_comb begin
    any_req = req0 | req1;
    winner  = REQ0;
    // On a tie the requester that did not win last time goes first.
    if (req0 && req1) begin
      winner = ~last_winner;
    end else if (req1) begin
      winner = REQ1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_read_arbiter.sv
//------------------------------------------------------------------------------
// rom_read_arbiter : shares one combinational ROM between two read requesters
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_ce,
  output logic              rom_read_en,
  input  logic [DATA_W-1:0] rom_data
);

  state_e            state_q, state_d;
  logic              winner_q, winner_d;
  logic              last_winner_q, last_winner_d;
  logic [ADDR_W-1:0] rom_address_q, rom_address_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

  logic w_any_req;
  logic w_pick;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_winner (last_winner_q),
    .any_req     (w_any_req),
    .winner      (w_pick)
  );

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    last_winner_d = last_winner_q;
    rom_address_d = rom_address_q;
    rdata_d       = rdata_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_any_req) begin
          state_d       = ACCESS;
          winner_d      = w_pick;
          last_winner_d = w_pick;
          rom_address_d = (w_pick == REQ1) ? addr1 : addr0;
          gnt0_d        = (w_pick == REQ0);
          gnt1_d        = (w_pick == REQ1);
        end
      end
      ACCESS: begin
        // ROM is enabled for this cycle only; capture its output at the edge.
        state_d   = RESP;
        rdata_d   = rom_data;
        rvalid0_d = (winner_q == REQ0);
        rvalid1_d = (winner_q == REQ1);
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      winner_q      <= REQ0;
      last_winner_q <= REQ1;
      rom_address_q <= '0;
      rdata_q       <= '0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      last_winner_q <= last_winner_d;
      rom_address_q <= rom_address_d;
      rdata_q       <= rdata_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata       = rdata_q;
  assign rom_address = rom_address_q;
  assign rom_ce      = (state_q == ACCESS);
  assign rom_read_en = (state_q == ACCESS);

endmodule

`default_nettype wire
